// File: rtl/ifns_enc_arbiter.sv
// Round-robin front end for one shared combinational IFNS 13->18 encoder core.
// One requester is granted per cycle; its codeword is registered with its id behind a valid/ready stage.

module ifns_enc_arbiter_lane #(
  parameter int DW = 13
) (
  input  logic          sel,
  input  logic          accept,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic [DW-1:0] data_m
);
  assign ready  = sel & accept;
  assign data_m = sel ? data : '0;
endmodule

module ifns_enc_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 13,
  parameter int CW   = 18,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNTW = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [DW-1:0]        core_din,
  input  logic [CW-1:0]        core_cw,
  output logic                 out_valid,
  output logic [CW-1:0]        out_code,
  output logic [IDW-1:0]       out_id,
  input  logic                 out_ready,
  output logic [CNTW-1:0]      xfer_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                   state;
  logic [IDW-1:0]           last_grant;
  logic [IDW-1:0]           gnt;
  logic [IDW-1:0]           idx;
  logic                     found;
  logic                     accept;
  logic                     xfer;
  logic [NREQ-1:0]          gnt_oh;
  logic [NREQ-1:0][DW-1:0]  data_a;
  logic [NREQ-1:0][DW-1:0]  data_m;

  assign data_a    = req_data;
  assign out_valid = (state == FULL);
  // rst_n gates accept so nothing is offered while the block is held in reset
  assign accept    = rst_n & ((state == EMPTY) | out_ready);
  assign xfer      = found & accept;

  // Search starts one past the last winner and wraps, giving rotating priority.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    gnt_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(last_grant) + 1 + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt         = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    ifns_enc_arbiter_lane #(.DW(DW)) u_lane (
      .sel    (gnt_oh[i]),
      .accept (accept),
      .data   (data_a[i]),
      .ready  (req_ready[i]),
      .data_m (data_m[i])
    );
  end

  always_comb begin
    core_din = '0;
    for (int i = 0; i < NREQ; i++) core_din = core_din | data_m[i];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_code   <= '0;
      out_id     <= '0;
      xfer_cnt   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (xfer) begin
      state      <= FULL;
      out_code   <= core_cw;
      out_id     <= gnt;
      last_grant <= gnt;
      xfer_cnt   <= xfer_cnt + 1'b1;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_ifns_enc_arbiter.sv
// Randomized bench for ifns_enc_arbiter against a rotating-priority queue-level model,
// with a stand-in combinational encoder core driving core_cw.

module tb_ifns_enc_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 13;
  localparam int CW   = 18;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic                 clock = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data  = '0;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        core_din;
  logic [CW-1:0]        core_cw;
  logic                 out_valid;
  logic [CW-1:0]        out_code;
  logic [IDW-1:0]       out_id;
  logic                 out_ready = 1'b0;
  logic [CNTW-1:0]      xfer_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Stand-in for the shared encoder core: any fixed data-dependent map exposes routing errors.
  function automatic logic [CW-1:0] core_fn(input logic [DW-1:0] d);
    return {d[4:0] ^ d[12:8], d ^ {d[0], d[12:1]}};
  endfunction

  assign core_cw = core_fn(core_din);

  ifns_enc_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .IDW(IDW), .CNTW(CNTW)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .core_din  (core_din),
    .core_cw   (core_cw),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_id    (out_id),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester strictly after 'last', wrapping; -1 if none.
  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Behavioural model: one held word, a rotating pointer and a counter.
  logic            m_valid;
  logic [CW-1:0]   m_code;
  int              m_id;
  int              m_last;
  logic [CNTW-1:0] m_cnt;
  int              mg;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_code  <= '0;
      m_id    <= 0;
      m_last  <= NREQ - 1;
      m_cnt   <= '0;
    end else begin
      mg = pick(m_last, req_valid);
      if (mg >= 0 && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_code  <= core_fn(req_data[mg*DW +: DW]);
        m_id    <= mg;
        m_last  <= mg;
        m_cnt   <= m_cnt + 1'b1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  int              cg;
  logic            cacc;
  logic [NREQ-1:0] cexp_rdy;
  logic [DW-1:0]   cexp_din;
  logic [NREQ-1:0] ghot;

  always @(negedge clock) begin
    cg   = pick(m_last, req_valid);
    cacc = rst_n && (!m_valid || out_ready);
    ghot = '0;
    if (cg >= 0) ghot[cg] = 1'b1;
    cexp_rdy = cacc ? ghot : '0;
    cexp_din = (cg >= 0) ? req_data[cg*DW +: DW] : '0;
    chk("req_ready", 32'(req_ready), 32'(cexp_rdy));
    chk("core_din",  32'(core_din),  32'(cexp_din));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_code",  32'(out_code),  32'(m_code));
    chk("out_id",    32'(out_id),    32'(m_id));
    chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
  end

  // Requester side: valid and data hold until accepted.
  logic [NREQ-1:0] acc = '0;
  bit              seq_mode = 1'b0;
  int              seq_cnt  = 0;

  task automatic gen_req(input int i);
    if (seq_mode && i == 0) begin
      if (seq_cnt < 8192) begin
        req_valid[0]  = 1'b1;
        req_data[0 +: DW] = DW'(seq_cnt);
        seq_cnt++;
      end else req_valid[0] = 1'b0;
    end else begin
      req_valid[i] = 1'b1;
      req_data[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] mask, input int rdy_pct, input int gen_pct);
    @(posedge clock);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !acc[i]) continue;
      if (mask[i] && $urandom_range(99) < gen_pct) gen_req(i);
      else req_valid[i] = 1'b0;
    end
    out_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clock);
    #1 acc = req_valid & req_ready;
  endtask

  task automatic apply_reset(input logic [NREQ-1:0] mask);
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) if (mask[i]) gen_req(i);
    out_ready = 1'b1;
    acc       = '0;
    repeat (2) @(posedge clock);
    #2 rst_n = 1'b1;
    @(negedge clock);
    #1 acc = req_valid & req_ready;
  endtask

  logic [DW-1:0] d_save;
  logic [CW-1:0] c_save;
  int            guard;
  logic [NREQ-1:0] rmask;

  initial begin
    #3;
    // Reset with everyone valid: requester 0 wins first, then strict rotation.
    apply_reset(4'b1111);
    chk("first_grant", 32'(req_ready), 32'h1);
    d_save = req_data[0 +: DW];
    for (int k = 0; k < 8; k++) begin
      if (k > 0) chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      step(4'b1111, 100, 100);
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_id",    32'(out_id),    32'(k % 4));
      if (k == 0) chk("first_code", 32'(out_code), 32'(core_fn(d_save)));
    end
    chk("cnt8", 32'(xfer_cnt), 32'd8);

    // Only 1 and 3 active: grants alternate.
    apply_reset(4'b1010);
    for (int k = 0; k < 8; k++) begin
      chk("alt_grant", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      step(4'b1010, 100, 100);
    end

    // Stall with requester 2 pending, then same-cycle refill.
    apply_reset(4'b0100);
    chk("stall_pre", 32'(req_ready), 32'h4);
    d_save = req_data[2*DW +: DW];
    step(4'b0100, 0, 100);
    c_save = out_code;
    chk("stall_code0", 32'(c_save), 32'(core_fn(d_save)));
    d_save = req_data[2*DW +: DW];
    for (int k = 0; k < 5; k++) begin
      chk("stall_rdy",  32'(req_ready), 32'h0);
      chk("stall_code", 32'(out_code),  32'(c_save));
      chk("stall_id",   32'(out_id),    32'h2);
      step(4'b0100, 0, 100);
    end
    step(4'b0100, 100, 100);
    chk("refill_rdy", 32'(req_ready), 32'h4);
    step(4'b0100, 100, 100);
    chk("refill_valid", 32'(out_valid), 32'h1);
    chk("refill_id",    32'(out_id),    32'h2);
    chk("refill_code",  32'(out_code),  32'(core_fn(d_save)));

    // Full 13-bit sweep through requester 0.
    seq_mode = 1'b1;
    seq_cnt  = 0;
    apply_reset(4'b0001);
    guard = 0;
    while (!(seq_cnt == 8192 && !req_valid[0]) && guard < 9000) begin
      step(4'b0001, 100, 100);
      guard++;
    end
    chk("sweep_done", 32'(guard < 9000), 32'h1);
    chk("sweep_cnt",  32'(xfer_cnt),     32'd8192);
    seq_mode = 1'b0;

    // Asynchronous reset mid-stream.
    apply_reset(4'b1111);
    repeat (5) step(4'b1111, 100, 100);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_cnt",   32'(xfer_cnt),  32'h0);
    chk("async_rdy",   32'(req_ready), 32'h0);
    acc = '0;
    @(posedge clock);
    #2 rst_n = 1'b1;
    @(negedge clock);
    #1 chk("post_rst_grant", 32'(req_ready), 32'h1);
    acc = req_valid & req_ready;

    // Random traffic and backpressure.
    rmask = NREQ'($urandom);
    apply_reset(rmask);
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) rmask = NREQ'($urandom);
      step(rmask, 60, 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifns_enc_arbiter.md
Name: ifns_enc_arbiter

Overview:
- Round-robin scheduler that shares one combinational IFNS 13-bit→18-bit encoder core (encoderIFNS_13di_core) between NREQ requesters.
- Selects one requester per cycle and drives the core input from that requester's data.
- Registers the core's codeword, tagged with the requester index, into a single output stage with valid/ready backpressure.
- Sits between multiple CAC traffic sources and the shared encoded bus driver. It replaces per-source IFNS_encoder_18 wrappers.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 13, data width into the core.
- CW, 18, codeword width out of the core.
- IDW, $clog2(NREQ), requester-id width.
- CNTW, 16, width of the accepted-word counter.

Ports:
- clock  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester data-valid.
- req_data  in  NREQ*DW  requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- core_din  out  DW  to core input v.
- core_cw  in  CW  from core outputs {d18..d1}; combinational from core_din.
- out_valid  out  1  codeword valid.
- out_code  out  CW  registered codeword.
- out_id  out  IDW  index of requester that produced out_code.
- out_ready  in  1  downstream accept.
- xfer_cnt  out  CNTW  total accepted words, wraps.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clock. While rst_n=0:
  - out_valid=0, out_code=0, out_id=0, xfer_cnt=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready=0.
- Reset asserted mid-operation discards the held word. No partial state survives.
- Output stage FSM:
  - EMPTY (out_valid=0): may accept.
  - FULL (out_valid=1): may accept only when out_ready=1 in the same cycle (pass-through refill).
- accept = ~out_valid | out_ready.
- Arbitration, combinational, each cycle:
  - Search req_valid starting at index last_grant+1 mod NREQ, ascending with wrap.
  - The first set bit is gnt.
  - If no req_valid is set, there is no grant.
- req_ready[gnt] = accept. All other req_ready bits are 0. req_ready never depends on out_valid being consumed by any path other than accept.
- core_din = req_data[gnt]. It is all-zero when there is no grant.
- Transfer = req_valid[gnt] & req_ready[gnt]. On a transfer, at the clock edge:
  - out_code <= core_cw.
  - out_id <= gnt.
  - out_valid <= 1.
  - last_grant <= gnt.
  - xfer_cnt <= xfer_cnt+1, wrapping from 2^CNTW-1 to 0.
- No transfer and out_ready=1: out_valid <= 0. out_code and out_id hold their last values.
- No transfer and out_ready=0: all output registers hold.
- Latency: one cycle from transfer to out_valid.
- Throughput: one word per cycle while out_ready=1.
- last_grant updates only on a transfer. A stalled grant keeps its priority, so the same requester stays granted until accepted.
- Requester rules: once req_valid is raised, it and req_data stay stable until accepted. A requester dropping valid early is a protocol violation and its behaviour is undefined.
- Output rules: out_code and out_id are stable while out_valid=1 and out_ready=0.
- Fairness: a continuously valid requester waits at most NREQ-1 transfers.
- NREQ=1 degenerates to a single valid/ready register stage with out_id=0.

Test Plan:
1. Reset with all req_valid=1 and out_ready=1, then release: first cycle gives req_ready=4'b0001. The next edge gives out_valid=1, out_id=0, and out_code equal to the golden IFNS model of req_data[0].
2. All four requesters valid with out_ready held at 1 for 8 cycles: out_id sequence is 0,1,2,3,0,1,2,3, one word per cycle, xfer_cnt=8.
3. Only requesters 1 and 3 valid with out_ready=1: grants alternate 1,3,1,3. Requesters 0 and 2 never see req_ready=1.
4. out_valid=1 with out_ready=0 for 5 cycles while requester 2 is valid: req_ready=0 throughout and out_code/out_id hold. Raising out_ready gives a same-cycle refill with out_id=2 on the next edge and no bubble.
5. Sweep all 8192 datain values through requester 0: every out_code matches the golden model, and xfer_cnt=8192 (mod 2^16).
6. Assert rst_n mid-stream with out_valid=1: out_valid drops immediately (asynchronously) and xfer_cnt=0. After release, requester 0 has priority again.
